output_port_scheduler: RTL

//  Packet-level scheduler for one router output port. Shares the port between NUM_OF_INPS input FIFOs

---
 rtl/router_pkg.sv | 13 +
 rtl/port_rr_pick.sv | 42 ++++
 rtl/output_port_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: scheduler state encoding and default datapath sizes
// used by the input FIFOs, crossbar and output port schedulers.
package router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } osched_state_e;

  localparam int DATA_WIDTH    = 8;
  localparam int MAX_PKT_FLITS = 16;

endpackage

// File: rtl/port_rr_pick.sv
// Stateless rotating-priority pick: scans requests starting at ptr and returns
// a one-hot grant plus the encoded index of the winner.
module port_rr_pick #(
  parameter int NUM_OF_INPS = 2,
  parameter int PTR_WIDTH   = $clog2(NUM_OF_INPS)
) (
  input  logic [NUM_OF_INPS-1:0] req,
  input  logic [PTR_WIDTH-1:0]   ptr,
  output logic [NUM_OF_INPS-1:0] grant,
  output logic [PTR_WIDTH-1:0]   winner
);

  logic                 found_s;
  logic [PTR_WIDTH-1:0] idx_s;
  int                   pos_s;

  // First requester at or after ptr, wrapping modulo NUM_OF_INPS.
  always_comb begin
    grant   = '0;
    winner  = '0;
    found_s = 1'b0;
    idx_s   = '0;
    pos_s   = 0;
    for (int k = 0; k < NUM_OF_INPS; k++) begin
      pos_s = int'(ptr) + k;
      if (pos_s >= NUM_OF_INPS) begin
        pos_s = pos_s - NUM_OF_INPS;
      end else begin
        pos_s = pos_s;
      end
      idx_s = PTR_WIDTH'(pos_s);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        winner       = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Packet-level round-robin scheduler for one router output port: locks the grant
// for a whole packet and drives the link through a one-entry valid/ready register.
module output_port_scheduler #(
  parameter int NUM_OF_INPS   = 2,
  parameter int DATA_WIDTH    = router_pkg::DATA_WIDTH,
  parameter int MAX_PKT_FLITS = router_pkg::MAX_PKT_FLITS,
  parameter int PTR_WIDTH     = $clog2(NUM_OF_INPS)
) (
  input  logic                              clk,
  input  logic                              rst_b,
  input  logic [NUM_OF_INPS-1:0]            in_valid,
  input  logic [NUM_OF_INPS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_OF_INPS-1:0]            in_last,
  output logic [NUM_OF_INPS-1:0]            in_ready,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  input  logic                              out_ready,
  output logic                              busy,
  output logic [PTR_WIDTH-1:0]              owner,
  output logic                              err_oversize
);

  import router_pkg::*;

  localparam int                   CNT_WIDTH = $clog2(MAX_PKT_FLITS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(MAX_PKT_FLITS - 1);
  localparam logic [PTR_WIDTH-1:0] TOP_PTR   = PTR_WIDTH'(NUM_OF_INPS - 1);

  osched_state_e           state_r;
  logic [PTR_WIDTH-1:0]    ptr_r;
  logic [PTR_WIDTH-1:0]    owner_r;
  logic [CNT_WIDTH-1:0]    flit_cnt_r;
  logic                    out_valid_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic                    out_last_r;
  logic                    err_r;

  logic [NUM_OF_INPS-1:0]  grant_s;
  logic [PTR_WIDTH-1:0]    winner_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic                    sel_last_s;
  logic                    in_beat_s;
  logic                    force_s;
  logic [PTR_WIDTH-1:0]    next_ptr_s;

  port_rr_pick #(
    .NUM_OF_INPS (NUM_OF_INPS),
    .PTR_WIDTH   (PTR_WIDTH)
  ) u_pick (
    .req    (in_valid),
    .ptr    (ptr_r),
    .grant  (grant_s),
    .winner (winner_s)
  );

  // Only the locked owner may pop, and only when the output register can take a flit.
  always_comb begin
    in_ready = '0;
    if (state_r == BUSY) begin
      in_ready[owner_r] = !out_valid_r || out_ready;
    end else begin
      in_ready = '0;
    end
  end

  assign sel_data_s = in_data[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last_s = in_last[owner_r];
  assign in_beat_s  = |(in_valid & in_ready);
  assign force_s    = in_beat_s && !sel_last_s && (flit_cnt_r == LAST_CNT);
  assign next_ptr_s = (owner_r == TOP_PTR) ? '0 : owner_r + PTR_WIDTH'(1);

  // Arbitration FSM, flit counter and registered output stage.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      owner_r     <= '0;
      flit_cnt_r  <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      if (in_beat_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
        out_last_r  <= sel_last_s || force_s;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            owner_r    <= winner_s;
            flit_cnt_r <= '0;
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          if (in_beat_s) begin
            flit_cnt_r <= flit_cnt_r + CNT_WIDTH'(1);
            // Oversize packets are cut here; the tail re-arbitrates as a new packet.
            if (sel_last_s || force_s) begin
              state_r <= IDLE;
              ptr_r   <= next_ptr_s;
              err_r   <= force_s;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_last     = out_last_r;
  assign busy         = (state_r == BUSY);
  assign owner        = owner_r;
  assign err_oversize = err_r;

endmodule
